req_rr_arbiter: RTL and testbench

Round-robin request arbiter that sits directly upstream of the 4-to-2 encoder. It turns four independent request lines into a single, stable one-hot grant vector `y0..y3`, which the encoder then converts to a 2-bit code. A valid/ready handshake holds each grant until the consumer accepts it. An optional idle gap can be inserted between consecutive grants.

---
 rtl/req_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_req_rr_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_rr_arbiter.sv
// Round-robin arbiter producing a stable one-hot grant with valid/ready handshake.
// Define ARB_STICKY_REQ_EN to remember request pulses until granted (default: level mode).
module req_rr_arbiter #(
  parameter int unsigned GRANT_GAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic       y0,
  output logic       y1,
  output logic       y2,
  output logic       y3,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] pending
);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] g_q, g_d;
  logic [3:0] gcnt_q, gcnt_d;

  logic [3:0] pick;
  logic [1:0] idx;
  logic [1:0] g_idx;
  logic       accept;
  logic [3:0] y;

  assign accept = (state_q == StGrant) && out_ready;

  // First pending bit at ptr+1, ptr+2, ... so the last winner ends up lowest priority.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (pick == '0 && pending_q[idx]) begin
        pick[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    case (g_q)
      4'b0001: g_idx = 2'd0;
      4'b0010: g_idx = 2'd1;
      4'b0100: g_idx = 2'd2;
      4'b1000: g_idx = 2'd3;
      default: g_idx = ptr_q;
    endcase
  end

`ifdef ARB_STICKY_REQ_EN
  logic [3:0] clear_mask;
  assign clear_mask = accept ? g_q : 4'b0000;
  // A new request on the clearing edge wins over the clear.
  assign pending_d = (pending_q & ~clear_mask) | req;
`else
  assign pending_d = req;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    gcnt_d  = gcnt_q;
    unique case (state_q)
      StIdle: begin
        if (pending_q != 4'b0000) begin
          g_d     = pick;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (accept) begin
          ptr_d = g_idx;
          if (GRANT_GAP == 0) begin
            state_d = StIdle;
          end else begin
            gcnt_d  = 4'(GRANT_GAP);
            state_d = StGap;
          end
        end
      end
      StGap: begin
        gcnt_d = gcnt_q - 4'd1;
        if (gcnt_q <= 4'd1) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= 4'b0000;
      ptr_q     <= 2'd3;
      g_q       <= 4'b0000;
      gcnt_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      g_q       <= g_d;
      gcnt_q    <= gcnt_d;
    end
  end

  assign out_valid = (state_q == StGrant);
  assign y         = out_valid ? g_q : 4'b0000;
  assign y0        = y[0];
  assign y1        = y[1];
  assign y2        = y[2];
  assign y3        = y[3];
  assign pending   = pending_q;

endmodule

// File: tb/tb_req_rr_arbiter.sv
// Directed bench for req_rr_arbiter: one instance with no grant gap, one with a gap of 3.
module tb_req_rr_arbiter;

  logic       clk;
  logic       rst0, rst3;
  logic [3:0] req0, req3;
  logic       rdy0, rdy3;
  logic       y0_0, y1_0, y2_0, y3_0, vld0;
  logic       y0_3, y1_3, y2_3, y3_3, vld3;
  logic [3:0] pend0, pend3;
  logic [3:0] yv0, yv3;

  int checks;
  int errors;

  assign yv0 = {y3_0, y2_0, y1_0, y0_0};
  assign yv3 = {y3_3, y2_3, y1_3, y0_3};

  req_rr_arbiter #(.GRANT_GAP(0)) dut0 (
    .clk       (clk),
    .rst       (rst0),
    .req       (req0),
    .y0        (y0_0),
    .y1        (y1_0),
    .y2        (y2_0),
    .y3        (y3_0),
    .out_valid (vld0),
    .out_ready (rdy0),
    .pending   (pend0)
  );

  req_rr_arbiter #(.GRANT_GAP(3)) dut3 (
    .clk       (clk),
    .rst       (rst3),
    .req       (req3),
    .y0        (y0_3),
    .y1        (y1_3),
    .y2        (y2_3),
    .y3        (y3_3),
    .out_valid (vld3),
    .out_ready (rdy3),
    .pending   (pend3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset0();
    rst0 = 1'b1;
    req0 = 4'b0000;
    rdy0 = 1'b0;
    tick();
    rst0 = 1'b0;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst3 = 1'b1;
    req0 = 4'b1111; req3 = 4'b1111;
    rdy0 = 1'b1; rdy3 = 1'b1;
    tick();
    tick();
    checks += 6;
    if (vld0 !== 1'b0) begin errors++; $display("FAIL reset_valid0 got %b exp 0", vld0); end
    if (yv0 !== 4'b0000) begin errors++; $display("FAIL reset_y0 got %b exp 0000", yv0); end
    if (pend0 !== 4'b0000) begin errors++; $display("FAIL reset_pend0 got %b exp 0000", pend0); end
    if (vld3 !== 1'b0) begin errors++; $display("FAIL reset_valid3 got %b exp 0", vld3); end
    if (yv3 !== 4'b0000) begin errors++; $display("FAIL reset_y3 got %b exp 0000", yv3); end
    if (pend3 !== 4'b0000) begin errors++; $display("FAIL reset_pend3 got %b exp 0000", pend3); end
    rst0 = 1'b0; rst3 = 1'b0;
    req0 = 4'b0000; req3 = 4'b0000;
    rdy0 = 1'b0; rdy3 = 1'b0;
  endtask

  // Single request: 2-edge latency, then pointer at 2 makes bit 3 win over bit 0.
  task automatic test_single();
    reset0();
    req0 = 4'b0100;
    rdy0 = 1'b1;
    tick();
    checks += 2;
    if (vld0 !== 1'b0) begin errors++; $display("FAIL single_e0_valid got %b exp 0", vld0); end
    if (pend0 !== 4'b0100) begin errors++; $display("FAIL single_e0_pend got %b exp 0100", pend0); end
    tick();
    checks += 2;
    if (vld0 !== 1'b1) begin errors++; $display("FAIL single_e1_valid got %b exp 1", vld0); end
    if (yv0 !== 4'b0100) begin errors++; $display("FAIL single_e1_y got %b exp 0100", yv0); end
    req0 = 4'b1011;
    tick();
    checks++;
    if (vld0 !== 1'b0) begin errors++; $display("FAIL single_e2_valid got %b exp 0", vld0); end
    tick();
    checks++;
    if (yv0 !== 4'b1000) begin errors++; $display("FAIL single_ptr2_next got %b exp 1000", yv0); end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_y;
    reset0();
    req0 = 4'b1111;
    rdy0 = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      exp_y = 4'b0001 << (i % 4);
      tick();
      checks += 2;
      if (vld0 !== 1'b1) begin errors++; $display("FAIL rot_valid[%0d] got %b exp 1", i, vld0); end
      if (yv0 !== exp_y) begin errors++; $display("FAIL rot_y[%0d] got %b exp %b", i, yv0, exp_y); end
      tick();
      checks += 2;
      if (vld0 !== 1'b0) begin errors++; $display("FAIL rot_gap[%0d] got %b exp 0", i, vld0); end
      if (!$onehot0(yv0)) begin errors++; $display("FAIL rot_onehot[%0d] got %b exp <=1 hot", i, yv0); end
    end
  endtask

  task automatic test_hold();
    reset0();
    req0 = 4'b0010;
    rdy0 = 1'b0;
    tick();
    tick();
    req0 = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      checks += 2;
      if (vld0 !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %b exp 1", i, vld0); end
      if (yv0 !== 4'b0010) begin errors++; $display("FAIL hold_y[%0d] got %b exp 0010", i, yv0); end
      tick();
    end
    rdy0 = 1'b1;
    tick();
    checks++;
    if (vld0 !== 1'b0) begin errors++; $display("FAIL hold_release got %b exp 0", vld0); end
    tick();
    checks++;
    if (yv0 !== 4'b1000) begin errors++; $display("FAIL hold_next got %b exp 1000", yv0); end
  endtask

`ifdef ARB_STICKY_REQ_EN
  task automatic test_pending();
    reset0();
    req0 = 4'b0001;
    tick();
    req0 = 4'b0000;
    tick();
    checks += 2;
    if (pend0 !== 4'b0001) begin errors++; $display("FAIL sticky_pend got %b exp 0001", pend0); end
    if (yv0 !== 4'b0001) begin errors++; $display("FAIL sticky_y got %b exp 0001", yv0); end
    tick();
    checks++;
    if (pend0 !== 4'b0001) begin errors++; $display("FAIL sticky_pend_hold got %b exp 0001", pend0); end
    rdy0 = 1'b1;
    tick();
    checks += 2;
    if (pend0 !== 4'b0000) begin errors++; $display("FAIL sticky_clear got %b exp 0000", pend0); end
    if (vld0 !== 1'b0) begin errors++; $display("FAIL sticky_done got %b exp 0", vld0); end
    rdy0 = 1'b0;
    req0 = 4'b0001;
    tick();
    req0 = 4'b0000;
    tick();
    rdy0 = 1'b1;
    req0 = 4'b0001;
    tick();
    req0 = 4'b0000;
    checks += 2;
    if (pend0 !== 4'b0001) begin errors++; $display("FAIL sticky_set_wins got %b exp 0001", pend0); end
    if (vld0 !== 1'b0) begin errors++; $display("FAIL sticky_set_valid got %b exp 0", vld0); end
  endtask
`else
  task automatic test_pending();
    reset0();
    req0 = 4'b0001;
    tick();
    req0 = 4'b0000;
    tick();
    checks += 2;
    if (pend0 !== 4'b0000) begin errors++; $display("FAIL level_pend got %b exp 0000", pend0); end
    if (yv0 !== 4'b0001) begin errors++; $display("FAIL level_grant_kept got %b exp 0001", yv0); end
    tick();
    checks++;
    if (vld0 !== 1'b1) begin errors++; $display("FAIL level_hold got %b exp 1", vld0); end
    rdy0 = 1'b1;
    tick();
    tick();
    checks += 2;
    if (vld0 !== 1'b0) begin errors++; $display("FAIL level_idle got %b exp 0", vld0); end
    if (pend0 !== 4'b0000) begin errors++; $display("FAIL level_empty got %b exp 0000", pend0); end
  endtask
`endif

  // Low cycles between grants: three GAP cycles plus the arbitration cycle in IDLE.
  task automatic test_gap();
    int low;
    bit seen;
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    req3 = 4'b0011;
    rdy3 = 1'b1;
    tick();
    tick();
    checks++;
    if (yv3 !== 4'b0001) begin errors++; $display("FAIL gap_first got %b exp 0001", yv3); end
    low  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (vld3) seen = 1'b1;
      else low++;
    end
    checks += 3;
    if (!seen) begin errors++; $display("FAIL gap_timeout got no grant exp grant within 20"); end
    if (low !== 4) begin errors++; $display("FAIL gap_low_cycles got %0d exp 4", low); end
    if (yv3 !== 4'b0010) begin errors++; $display("FAIL gap_second got %b exp 0010", yv3); end
  endtask

  task automatic test_reset_mid();
    reset0();
    req0 = 4'b1010;
    rdy0 = 1'b1;
    tick();
    tick();
    tick();
    rdy0 = 1'b0;
    tick();
    checks++;
    if (yv0 !== 4'b1000) begin errors++; $display("FAIL mid_pre got %b exp 1000", yv0); end
    rst0 = 1'b1;
    req0 = 4'b0110;
    tick();
    checks += 3;
    if (vld0 !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", vld0); end
    if (pend0 !== 4'b0000) begin errors++; $display("FAIL mid_pend got %b exp 0000", pend0); end
    if (yv0 !== 4'b0000) begin errors++; $display("FAIL mid_y got %b exp 0000", yv0); end
    rst0 = 1'b0;
    tick();
    tick();
    checks++;
    if (yv0 !== 4'b0010) begin errors++; $display("FAIL mid_after got %b exp 0010", yv0); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst0 = 1'b1; rst3 = 1'b1;
    req0 = 4'b0000; req3 = 4'b0000;
    rdy0 = 1'b0; rdy3 = 1'b0;
    #1;
    test_reset();
    test_single();
    test_rotation();
    test_hold();
    test_pending();
    test_gap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
